// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and default width for the programmable clock divider
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed divisor reload, clean stop and phase sync
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             sync,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_d,
  output logic             tick,
  output logic             busy
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] shadow_q, shadow_d, active_q, active_d, count_q, count_d, next_div;
  logic clk_d_q, clk_d_d, tick_q, tick_d, tc;
  always_comb begin
    next_div = load ? div_in : shadow_q;
    tc = count_q == active_q;
    shadow_d = next_div;
    state_d = state_q;
    active_d = active_q;
    count_d = count_q;
    clk_d_d = clk_d_q;
    tick_d = 1'b0;
    if (state_q == IDLE) begin
      count_d = '0;
      clk_d_d = 1'b0;
      state_d = en ? RUN : IDLE;
      active_d = en ? next_div : active_q;
    end else if (sync) begin
      count_d = '0;
      clk_d_d = 1'b0;
      active_d = next_div;
      state_d = state_q == STOP ? IDLE : RUN;
    end else begin
      count_d = tc ? '0 : count_q + 1'b1;
      clk_d_d = clk_d_q ^ tc;
      tick_d = tc;
      active_d = tc ? next_div : active_q;
      state_d = en ? RUN : (state_q == STOP && tc && clk_d_q) ? IDLE : STOP;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      count_q <= '0;
      clk_d_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q <= count_d;
      clk_d_q <= clk_d_d;
      tick_q <= tick_d;
    end
  end
  assign clk_d = clk_d_q;
  assign tick = tick_q;
  assign busy = state_q != IDLE;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: NUM_CH independent programmable clock dividers; CLK_DIV_SYNC_EN adds a phase-align sync input
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef CLK_DIV_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  output logic [NUM_CH-1:0]       clk_d,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);
  logic sync_w;
`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[i]),
      .load   (load[i]),
      .sync   (sync_w),
      .div_in (div_in[i*CNT_W +: CNT_W]),
      .clk_d  (clk_d[i]),
      .tick   (tick[i]),
      .busy   (busy[i])
    );
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog (2 channels, 4-bit divisors)
module tb_clk_div_prog;
  logic clk = 1'b0, rst_n = 1'b0, sync = 1'b0;
  logic [1:0] en = '0, load = '0;
  logic [7:0] div_in = '0;
  logic [1:0] clk_d, tick, busy;
  int tests = 0, fails = 0;
  int n;
  clk_div_prog #(.NUM_CH(2), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef CLK_DIV_SYNC_EN
    .sync   (sync),
`endif
    .en     (en),
    .load   (load),
    .div_in (div_in),
    .clk_d  (clk_d),
    .tick   (tick),
    .busy   (busy)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wave(input string tag, input int cnt, input logic [63:0] ec, input logic [63:0] et);
    for (int i = 0; i < cnt; i++) begin
      cyc();
      chk($sformatf("%s clk_d cyc%0d", tag, i + 1), int'(clk_d[0]), int'(ec[cnt-1-i]));
      chk($sformatf("%s tick cyc%0d", tag, i + 1), int'(tick[0]), int'(et[cnt-1-i]));
    end
  endtask
  task automatic next_edge(input logic v, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (clk_d[0] !== v && cnt < 200);
  endtask
  initial begin
    cyc();
    cyc();
    chk("reset clk_d", int'(clk_d), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    div_in[3:0] = 4'd3;
    load = 2'b01;
    cyc();
    load = 2'b00;
    en = 2'b01;
    cyc();
    chk("start busy", int'(busy[0]), 1);
    chk("start clk_d", int'(clk_d[0]), 0);
    wave("d3", 16, 64'b0001111000011110, 64'b0001000100010001);
    en = 2'b00;
    repeat (9) cyc();
    chk("d3 stopped busy", int'(busy[0]), 0);
    chk("d3 stopped clk_d", int'(clk_d[0]), 0);
    div_in[3:0] = 4'd0;
    load = 2'b01;
    en = 2'b01;
    cyc();
    load = 2'b00;
    wave("d0", 8, 64'b10101010, 64'b11111111);
    en = 2'b00;
    wave("d0 stop", 3, 64'b100, 64'b110);
    chk("d0 stop busy", int'(busy[0]), 0);
    div_in[3:0] = 4'd15;
    load = 2'b01;
    en = 2'b01;
    cyc();
    load = 2'b00;
    next_edge(1'b1, n);
    chk("dmax first rise", n, 16);
    next_edge(1'b0, n);
    chk("dmax high", n, 16);
    next_edge(1'b1, n);
    chk("dmax low", n, 16);
    rst_n = 1'b0;
    #1;
    chk("async rst clk_d", int'(clk_d[0]), 0);
    chk("async rst tick", int'(tick[0]), 0);
    chk("async rst busy", int'(busy[0]), 0);
    en = 2'b00;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post rst idle busy", int'(busy[0]), 0);
    chk("post rst idle clk_d", int'(clk_d[0]), 0);
    div_in[3:0] = 4'd3;
    load = 2'b01;
    en = 2'b01;
    cyc();
    load = 2'b00;
    wave("reload pre", 5, 64'b00011, 64'b00010);
    div_in[3:0] = 4'd1;
    load = 2'b01;
    wave("reload ld", 1, 64'b1, 64'b0);
    load = 2'b00;
    wave("reload d1", 8, 64'b10011001, 64'b01010101);
    wave("tcload pre", 1, 64'b1, 64'b0);
    div_in[3:0] = 4'd2;
    load = 2'b01;
    wave("tcload tc", 1, 64'b0, 64'b1);
    load = 2'b00;
    wave("tcload d2", 6, 64'b001110, 64'b001001);
    en = 2'b00;
    wave("stop low", 7, 64'b0011100, 64'b0010010);
    chk("stop idle busy", int'(busy[0]), 0);
    en = 2'b01;
    cyc();
    wave("rerun", 3, 64'b001, 64'b001);
    en = 2'b00;
    wave("stop hi", 1, 64'b1, 64'b0);
    chk("stop hi busy", int'(busy[0]), 1);
    en = 2'b01;
    wave("resume", 8, 64'b10001110, 64'b01001001);
    chk("ch1 idle clk_d", int'(clk_d[1]), 0);
    chk("ch1 idle busy", int'(busy[1]), 0);
`ifdef CLK_DIV_SYNC_EN
    rst_n = 1'b0;
    en = 2'b00;
    cyc();
    rst_n = 1'b1;
    div_in = {4'd5, 4'd2};
    load = 2'b11;
    cyc();
    load = 2'b00;
    en = 2'b01;
    cyc();
    en = 2'b11;
    repeat (5) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sync clk_d", int'(clk_d), 0);
    chk("sync tick", int'(tick), 0);
    begin
      int r0 = 0, r1 = 0;
      for (int i = 1; i <= 8; i++) begin
        cyc();
        if (clk_d[0] && r0 == 0) r0 = i;
        if (clk_d[1] && r1 == 0) r1 = i;
      end
      chk("sync ch0 rise", r0, 3);
      chk("sync ch1 rise", r1, 6);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
